// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: receives framed serial codewords (start low, data_l bits LSB
// first, stop high) and presents each accepted word on data with an avl toggle.
module cmd_frame_rx #(
    parameter int data_l       = 14,
    parameter int clks_per_bit = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [data_l-1:0] data,
    output logic              avl,
    output logic              busy,
    output logic [3:0]        frame_err
);

    localparam int CW = $clog2(clks_per_bit);
    localparam int IW = $clog2(data_l);

    localparam logic [CW-1:0] CNT_HALF = CW'(clks_per_bit / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(clks_per_bit - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(data_l - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [data_l-1:0] sr, sr_n;
    logic [data_l-1:0] data_n;
    logic              avl_n;
    logic              busy_n;
    logic [3:0]        frame_err_n;
    logic [1:0]        sync_q;
    logic              rx_s;

    assign rx_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous command line, idling high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Frame state machine: next state, counters, shift register and outputs.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        sr_n        = sr;
        data_n      = data;
        avl_n       = avl;
        frame_err_n = frame_err;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        idx_n   = '0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    sr_n  = {rx_s, sr[data_l-1:1]};
                    if (idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n      = sr;
                        avl_n       = ~avl;
                        frame_err_n = 4'd0;
                        state_n     = IDLE;
                    end else begin
                        if (frame_err != 4'd15) begin
                            frame_err_n = frame_err + 4'd1;
                        end
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state == START) || (state == DATA) || (state == STOP);
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sr        <= '0;
            data      <= '0;
            avl       <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 4'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sr        <= sr_n;
            data      <= data_n;
            avl       <= avl_n;
            busy      <= busy_n;
            frame_err <= frame_err_n;
        end
    end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Testbench for cmd_frame_rx: directed and randomised frames against a
// frame-level reference model (expected word, avl level, error count).
module tb_cmd_frame_rx;

    localparam int DL  = 14;
    localparam int CPB = 16;
    localparam int FRAME_BITS_CYC = CPB * (DL + 1);

    logic          clk;
    logic          rst;
    logic          rx;
    logic [DL-1:0] data;
    logic          avl;
    logic          busy;
    logic [3:0]    frame_err;

    int tests = 0;
    int fails = 0;

    logic [DL-1:0] exp_data;
    logic          exp_avl;
    int            exp_fe;

    cmd_frame_rx #(
        .data_l      (DL),
        .clks_per_bit(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .avl      (avl),
        .busy     (busy),
        .frame_err(frame_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level n cycles after the start bit's falling edge.
    function automatic logic rx_level(input logic [DL-1:0] payload, input logic stop_val, input int n);
        if (n < CPB) return 1'b0;
        if (n < FRAME_BITS_CYC) return payload[(n - CPB) / CPB];
        return stop_val;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected effect of one complete frame on the outputs.
    task automatic model_frame(input logic [DL-1:0] payload, input logic good);
        if (good) begin
            exp_data = payload;
            exp_avl  = ~exp_avl;
            exp_fe   = 0;
        end else if (exp_fe < 15) begin
            exp_fe = exp_fe + 1;
        end
    endtask

    // Drive a frame starting at a falling clock edge; stop level held stop_len cycles.
    task automatic apply_frame(input logic [DL-1:0] payload, input logic stop_val, input int stop_len);
        for (int n = 0; n < FRAME_BITS_CYC + stop_len; n++) begin
            rx = rx_level(payload, stop_val, n);
            @(negedge clk);
        end
    endtask

    task automatic apply_idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_data"}, 32'(data), 32'(exp_data));
        check_output({tag, "_avl"}, 32'(avl), 32'(exp_avl));
        check_output({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
    endtask

    initial begin
        logic [DL-1:0] p;

        rst      = 1'b0;
        rx       = 1'b1;
        exp_data = '0;
        exp_avl  = 1'b0;
        exp_fe   = 0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_model("reset");
        rst = 1'b1;
        apply_idle(5);

        // Clean frame with exact timing of avl and busy.
        for (int n = 0; n < 260; n++) begin
            rx = rx_level(14'h1A5C, 1'b1, n);
            @(negedge clk);
            if (n + 1 == 3)   check_output("t1_busy_pre", 32'(busy), 32'd0);
            if (n + 1 == 4)   check_output("t1_busy_rise", 32'(busy), 32'd1);
            if (n + 1 == 250) check_output("t1_avl_pre", 32'(avl), 32'd0);
            if (n + 1 == 251) begin
                check_output("t1_avl_edge", 32'(avl), 32'd1);
                check_output("t1_data_edge", 32'(data), 32'h1A5C);
                check_output("t1_busy_last", 32'(busy), 32'd1);
            end
            if (n + 1 == 252) check_output("t1_busy_fall", 32'(busy), 32'd0);
        end
        model_frame(14'h1A5C, 1'b1);
        check_model("t1");

        // Back-to-back frames with a short stop bit on the first.
        apply_frame(14'h3FFF, 1'b1, 10);
        model_frame(14'h3FFF, 1'b1);
        apply_frame(14'h0001, 1'b1, CPB);
        model_frame(14'h0001, 1'b1);
        apply_idle(20);
        check_model("b2b");

        // Three-cycle glitch on an idle line.
        for (int n = 0; n < 20; n++) begin
            rx = (n < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (n + 1 == 3)  check_output("gl_busy_pre", 32'(busy), 32'd0);
            if (n + 1 == 4)  check_output("gl_busy_rise", 32'(busy), 32'd1);
            if (n + 1 == 11) check_output("gl_busy_last", 32'(busy), 32'd1);
            if (n + 1 == 12) check_output("gl_busy_fall", 32'(busy), 32'd0);
        end
        check_model("glitch");

        // Low stop bit, line held low 100 more cycles: no restart while low.
        apply_frame(14'h1234, 1'b0, CPB + 100);
        model_frame(14'h1234, 1'b0);
        check_output("brk_busy", 32'(busy), 32'd0);
        apply_idle(20);
        check_model("bad1");

        // Sixteen more bad frames drive the count into saturation.
        for (int k = 0; k < 16; k++) begin
            p = DL'($urandom);
            apply_frame(p, 1'b0, CPB + $urandom_range(0, 40));
            model_frame(p, 1'b0);
            apply_idle($urandom_range(3, 20));
            check_model("bad_sat");
        end

        // Random good frames with random stop lengths and idle gaps.
        for (int k = 0; k < 8; k++) begin
            p = DL'($urandom);
            apply_frame(p, 1'b1, $urandom_range(10, 24));
            model_frame(p, 1'b1);
            apply_idle($urandom_range(2, 20));
            check_model("rand_good");
        end

        // Known non-zero word before the reset test.
        apply_frame(14'h2DB7, 1'b1, CPB);
        model_frame(14'h2DB7, 1'b1);
        apply_idle(5);
        check_model("pre_rst");

        // Reset asserted in the middle of data bit 7.
        p = DL'($urandom);
        for (int n = 0; n < CPB + 7 * CPB + CPB / 2; n++) begin
            rx = rx_level(p, 1'b1, n);
            @(negedge clk);
        end
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        exp_data = '0;
        exp_avl  = 1'b0;
        exp_fe   = 0;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_model("rst_mid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        apply_idle(300);
        check_output("post_rst_busy", 32'(busy), 32'd0);
        check_model("post_rst_quiet");
        apply_frame(14'h0ABC, 1'b1, CPB);
        model_frame(14'h0ABC, 1'b1);
        apply_idle(5);
        check_model("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
